// File: rtl/uart_tx_fifo.sv
// UART transmit path: byte FIFO filled by MMIO writes, drained by an 8N1 serializer on uart_tx.
// tx_busy/tx_data are registered and observed by echo monitors, so their cycle timing is fixed.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 234,
   parameter int unsigned DEPTH        = 16,
   localparam int unsigned AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic [AW:0]   level,
   output logic          overflow,
   input  logic          clr_overflow,
   output logic          tx_busy,
   output logic [7:0]    tx_data,
   output logic          uart_tx
);

   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic          full_q, full_d;
   logic          overflow_q;

   state_e        state_q;
   logic [CW-1:0] baud_q;
   logic [2:0]    idx_q;
   logic [7:0]    tx_data_q;
   logic          tx_q;
   logic          busy_q;

   logic          push_c, pop_c, bit_end_c;

   // Push sees only the pre-edge full flag; a same-edge pop never frees a slot for it.
   assign push_c    = wr_en && !full_q;
   assign pop_c     = (state_q == IDLE) && (level_q != '0);
   assign bit_end_c = (baud_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      level_d = level_q;
      if (push_c && !pop_c) begin
         level_d = level_q + LW'(1);
      end else if (pop_c && !push_c) begin
         level_d = level_q - LW'(1);
      end
      full_d = (level_d == LW'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // FIFO bookkeeping and the sticky overflow flag (a drop beats a clear).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         level_q <= level_d;
         full_q  <= full_d;
         if (wr_en && full_q) begin
            overflow_q <= 1'b1;
         end else if (clr_overflow) begin
            overflow_q <= 1'b0;
         end
      end
   end

   // Serializer; STOP always returns to IDLE so busy drops for at least one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         idx_q     <= '0;
         tx_data_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (pop_c) begin
                  tx_data_q <= mem_q[rd_ptr_q];
                  busy_q    <= 1'b1;
                  tx_q      <= 1'b0;
                  baud_q    <= '0;
                  state_q   <= START;
               end
            end
            START: begin
               if (bit_end_c) begin
                  baud_q  <= '0;
                  idx_q   <= '0;
                  tx_q    <= tx_data_q[0];
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            DATA: begin
               if (bit_end_c) begin
                  baud_q <= '0;
                  if (idx_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                     tx_q  <= tx_data_q[idx_q + 3'd1];
                  end
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            STOP: begin
               if (bit_end_c) begin
                  baud_q  <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign full     = full_q;
   assign level    = level_q;
   assign overflow = overflow_q;
   assign tx_busy  = busy_q;
   assign tx_data  = tx_data_q;
   assign uart_tx  = tx_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit side of the SoC UART: a byte FIFO that CPU-side MMIO writes fill, plus an 8N1 serializer that drives the `uart_tx` pin.
- It produces the `tx_busy`/`tx_data` pair that bench monitors sample to echo characters, so their timing is part of the contract.
- Sits between the UART MMIO register decode (upstream) and the board pin (downstream).

Parameters:
- CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200); must be ≥ 2.
- DEPTH, 16, FIFO entries; power of 2, ≥ 2.
- AW, $clog2(DEPTH), FIFO pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock (27 MHz)
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  push request, one byte per cycle
- wr_data  in  8  byte to push
- full  out  1  FIFO holds DEPTH bytes
- level  out  AW+1  FIFO occupancy 0..DEPTH; excludes the byte being shifted
- overflow  out  1  sticky: a push was dropped
- clr_overflow  in  1  clears overflow
- tx_busy  out  1  frame in progress (start bit through stop bit)
- tx_data  out  8  byte currently/last transmitted
- uart_tx  out  1  serial line, idle high

Behaviour:
- Reset (async assert, sync-style release): uart_tx=1, tx_busy=0, tx_data=0, level=0, full=0, overflow=0, FSM=IDLE, pointers=0, baud and bit counters=0.
- Reset mid-frame: line goes high immediately, frame aborted, FIFO contents discarded.
- Push rule:
  - Accepted at a rising edge when wr_en=1 and full=0 (full as registered before that edge).
  - A pop at the same edge does not make room for a push in that cycle.
  - A push with full=1 is dropped and sets overflow at that edge.
- overflow clears at the edge where clr_overflow=1.
  - If a drop and clr_overflow coincide, overflow remains 1 (set wins).
- level/full are registered and reflect all pushes/pops through the previous edge. Simultaneous push+pop leaves level unchanged.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx_busy=0, uart_tx=1.
  - If level≠0 at an edge: pop the head into the shift register and tx_data, set tx_busy=1 and uart_tx=0, go to START, clear the baud counter.
  - A byte pushed into an empty idle FIFO at edge E0 is popped at edge E1, so the start bit begins after E1.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - uart_tx = shift[idx], LSB first; each bit lasts CLKS_PER_BIT cycles.
  - After idx=7 expires, go to STOP.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
- IDLE lasts at least one full cycle with tx_busy=0 between frames, even with the FIFO non-empty. Monitors depend on seeing that low cycle.
- Frame length: 10×CLKS_PER_BIT cycles with tx_busy=1. Inter-frame gap: exactly 1 cycle when back-to-back.
- tx_data is stable from the pop edge until the next pop.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary. FIFO pointers are AW bits and wrap naturally.
- Capacity: with 1 byte in the shift register, DEPTH+1 back-to-back pushes into an idle, empty block are all accepted (the first is popped at edge E1). Push DEPTH+2 is dropped.

Test Plan:
- CLKS_PER_BIT=4: push 0x41 once into idle block → tx_busy rises at E1. uart_tx sequence is 0,1,0,0,0,0,0,1,0,1, each 4 cycles. tx_busy high 40 cycles, tx_data=0x41, level returns to 0.
- Push "Hi" (0x48, 0x69) on consecutive cycles → two frames, tx_busy low exactly 1 cycle between them. A monitor capturing tx_data on each busy rise prints "Hi".
- DEPTH=16: 18 consecutive pushes 0x00..0x11 from idle → full=1 and level=16 after the 17th, overflow=1 after the 18th. Bytes 0x00..0x10 are transmitted in order; 0x11 never appears.
- Pulse clr_overflow while a dropped push occurs in the same cycle → overflow stays 1. A lone clr_overflow the next cycle → overflow=0.
- With FIFO full, assert wr_en during the IDLE pop edge → push dropped (overflow=1), level=15 after that edge.
- Assert reset low mid-DATA of 0x55 with 3 bytes queued → uart_tx=1 and tx_busy=0 immediately, level=0. After release, the line stays idle high for 100 cycles.
